// File: rtl/soc_pio_gen_if.sv
// Register bus between a host and the PIO block: 3-bit address, active-low
// write strobe qualified by chipselect, and zero-wait-state combinational read data.
interface soc_pio_gen_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_pio_gen.sv
// Parallel I/O port: output register with set/clear aliases, per-bit direction,
// synchronized inputs with edge capture (write-1-to-clear) and a masked level irq.
module soc_pio_gen #(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned     EDGE_TYPE   = 0,
  parameter int unsigned     IRQ_EN      = 1
) (
  input  logic               clk,
  input  logic               reset,
  soc_pio_gen_if.slave       bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic [WIDTH-1:0]   out_port,
  output logic [WIDTH-1:0]   oe,
  output logic               irq
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_edge_det;
  logic [WIDTH-1:0] w_edge_clr;
  logic [WIDTH-1:0] w_rd;

  assign w_wr    = bus.chipselect && !bus.write_n;
  assign w_wdata = bus.writedata[WIDTH-1:0];

  always_comb begin
    w_edge_det = '0;
    case (EDGE_TYPE)
      0:       w_edge_det = r_sync2 & ~r_prev;
      1:       w_edge_det = ~r_sync2 & r_prev;
      default: w_edge_det = r_sync2 ^ r_prev;
    endcase
  end

  always_comb begin
    w_edge_clr = '0;
    if (w_wr && bus.address == 3'd3) w_edge_clr = w_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= RESET_VALUE;
      r_dir   <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      // New edges are OR'd in after the clear so a coincident capture survives.
      r_edge  <= (r_edge & ~w_edge_clr) | w_edge_det;
      r_irq   <= (IRQ_EN != 0) && (|(r_edge & r_mask));
      if (w_wr) begin
        case (bus.address)
          3'd0: r_data <= w_wdata;
          3'd1: r_dir  <= w_wdata;
          3'd2: if (IRQ_EN != 0) r_mask <= w_wdata;
          3'd4: r_data <= r_data | w_wdata;
          3'd5: r_data <= r_data & ~w_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (bus.address)
      3'd0:    w_rd = (r_sync2 & ~r_dir) | (r_data & r_dir);
      3'd1:    w_rd = r_dir;
      3'd2:    w_rd = r_mask;
      3'd3:    w_rd = r_edge;
      default: w_rd = '0;
    endcase
  end

  assign bus.readdata = 32'(w_rd);
  assign out_port     = r_data;
  assign oe           = r_dir;
  assign irq          = r_irq;

endmodule

// File: tb/tb_soc_pio_gen.sv
// Directed bench for soc_pio_gen (WIDTH=8, RESET_VALUE=0x3C, rising edges, irq on).
module tb_soc_pio_gen;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic [7:0] oe;
  logic       irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  soc_pio_gen_if bus ();

  soc_pio_gen #(
    .WIDTH       (8),
    .RESET_VALUE (8'h3C),
    .EDGE_TYPE   (0),
    .IRQ_EN      (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port),
    .oe       (oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    reset          = 1'b1;
    in_port        = 8'h00;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tick(2);
    reset = 1'b0;

    check("rst_out", {24'h0, out_port}, 32'h3C);
    check("rst_oe", {24'h0, oe}, 32'h00);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rd(3'd3, v); check("rst_edge", v, 32'h0);
    rd(3'd2, v); check("rst_mask", v, 32'h0);
    rd(3'd0, v); check("rst_data_in", v, 32'h0);

    // Output register path
    wr(3'd1, 32'h0000_00FF);
    wr(3'd0, 32'hFFFF_FFA5);
    check("data_out", {24'h0, out_port}, 32'hA5);
    check("dir_oe", {24'h0, oe}, 32'hFF);
    rd(3'd0, v); check("data_read", v, 32'h0000_00A5);
    wr(3'd0, 32'h0F);
    check("data_0f", {24'h0, out_port}, 32'h0F);
    wr(3'd4, 32'h30);
    check("outset", {24'h0, out_port}, 32'h3F);
    wr(3'd5, 32'h01);
    check("outclr", {24'h0, out_port}, 32'h3E);
    rd(3'd4, v); check("outset_rd", v, 32'h0);
    rd(3'd5, v); check("outclr_rd", v, 32'h0);

    // Rising edge on bit2 with mask, then irq and W1C
    wr(3'd2, 32'h04);
    rd(3'd2, v); check("mask_rd", v, 32'h04);
    in_port = 8'h04;
    tick(2);
    rd(3'd3, v); check("edge_early", v, 32'h0);
    tick();
    rd(3'd3, v); check("edge_3rd", v, 32'h04);
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    tick();
    check("irq_set", {31'h0, irq}, 32'h1);
    rd(3'd0, v); check("data_mixed", v, 32'h3E);
    wr(3'd3, 32'h04);
    rd(3'd3, v); check("edge_w1c", v, 32'h0);
    check("irq_lag", {31'h0, irq}, 32'h1);
    tick();
    check("irq_clr", {31'h0, irq}, 32'h0);

    // Clear and capture on the same edge: capture wins
    in_port = 8'h05;
    tick(2);
    wr(3'd3, 32'h01);
    rd(3'd3, v); check("set_wins", v, 32'h01);
    wr(3'd3, 32'h01);
    rd(3'd3, v); check("edge_clr0", v, 32'h0);

    // Falling edges ignored for rising-edge capture
    in_port = 8'h00;
    tick(4);
    rd(3'd3, v); check("no_fall", v, 32'h0);
    check("no_fall_irq", {31'h0, irq}, 32'h0);

    // Raise irq, then reset during a DATA write
    in_port = 8'h04;
    tick(4);
    check("irq_again", {31'h0, irq}, 32'h1);
    reset          = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'hFF;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    reset          = 1'b0;
    check("rw_out", {24'h0, out_port}, 32'h3C);
    check("rw_oe", {24'h0, oe}, 32'h00);
    check("rw_irq", {31'h0, irq}, 32'h0);
    rd(3'd3, v); check("rw_edge", v, 32'h0);
    rd(3'd2, v); check("rw_mask", v, 32'h0);

    // Held-1 input after reset yields exactly one rising capture
    tick(2);
    rd(3'd3, v); check("held_early", v, 32'h0);
    tick();
    rd(3'd3, v); check("held_capture", v, 32'h04);
    wr(3'd3, 32'h04);
    tick(3);
    rd(3'd3, v); check("held_once", v, 32'h0);
    rd(3'd0, v); check("data_in_sync", v, 32'h04);

    // Unmapped addresses
    rd(3'd6, v); check("rd6", v, 32'h0);
    rd(3'd7, v); check("rd7", v, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    check("unm_out", {24'h0, out_port}, 32'h3C);
    check("unm_oe", {24'h0, oe}, 32'h00);
    rd(3'd2, v); check("unm_mask", v, 32'h0);
    rd(3'd3, v); check("unm_edge", v, 32'h0);
    rd(3'd6, v); check("rd6_after", v, 32'h0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
